// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the consumer acks it or until TIMEOUT cycles
// have passed without an ack. Either way the grant is followed by at
// least one idle cycle, so the downstream encoder always sees a gap.
//
// state | meaning
// IDLE  | no grant outstanding; the next edge grants if any req is set
// GRANT | Y holds one requester; waiting for ack or for the hold limit
module rr_arbiter4 #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] Y,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Value of cnt on the last cycle a grant may stay visible.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] y_n;
  logic       valid_n;
  logic       timeout_n;
  logic [1:0] win;
  logic [1:0] gnt_idx;

  // Pick the first requester above the last winner, wrapping modulo 4.
  // Walking the offsets downward lets the nearest requester overwrite
  // the farther ones; offset 4 is the last winner itself.
  always_comb begin
    win = ptr + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
  end

  // Recover the index of the held grant for the pointer update on release.
  always_comb begin
    case (Y)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  // Next-state and next-output logic; timeout is a one-cycle pulse.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    y_n       = Y;
    valid_n   = valid;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          y_n     = 4'b0001 << win;
          valid_n = 1'b1;
          cnt_n   = 4'd0;
          state_n = GRANT;
        end else begin
          y_n     = 4'b0000;
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (ack) begin
          y_n     = 4'b0000;
          valid_n = 1'b0;
          ptr_n   = gnt_idx;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          y_n       = 4'b0000;
          valid_n   = 1'b0;
          timeout_n = 1'b1;
          ptr_n     = gnt_idx;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        y_n     = 4'b0000;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers; ptr resets to 3 so req[0] leads after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      cnt     <= 4'd0;
      Y       <= 4'b0000;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      Y       <= y_n;
      valid   <= valid_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001: Parameter TIMEOUT, default 8. It is the maximum number of cycles a grant is held without ack. Legal range is 1..15.
REQ-002: clk  input  1  Single clock; all state updates on the rising edge.
REQ-003: rst  input  1  Asynchronous, active-high reset.
REQ-004: req  input  4  Request lines; bit i set means requester i wants service; any combination is legal.
REQ-005: ack  input  1  Downstream consumer has taken the current grant; sampled on the rising edge of clk.
REQ-006: Y  output  4  One-hot registered grant vector, or 4'b0000 when nothing is granted. It feeds the downstream 4-to-2 encoder directly.
REQ-007: valid  output  1  Registered; high exactly when Y is nonzero.
REQ-008: timeout  output  1  Registered; one-cycle pulse when a grant is dropped for lack of ack.

Function
REQ-009: The block SHALL implement exactly two states, IDLE and GRANT, plus these registers:
- 2-bit last-winner pointer ptr
- 4-bit hold counter cnt
REQ-010: Y SHALL be registered, with no combinational path from req or ack to Y, valid or timeout.
REQ-011: In IDLE with req == 0, the block SHALL stay in IDLE with Y=0, valid=0 and timeout=0.
REQ-012: In IDLE with req != 0 at an edge, the block SHALL, at that same edge, do all of the following:
- Y <= onehot(win)
- valid <= 1
- cnt <= 0
- state <= GRANT
This gives one-cycle latency from req sampled to Y.
REQ-013: win SHALL be the first set bit of req searching upward from index ptr+1 modulo 4.
- Example: ptr=1 gives search order 2, 3, 0, 1.
REQ-014: In GRANT, Y SHALL hold stable regardless of req changes, including the granted requester dropping its req.
REQ-015: In GRANT with ack=1 at an edge, the block SHALL at that edge do all of the following:
- Y <= 0
- valid <= 0
- ptr <= index of current grant
- state <= IDLE
REQ-016: In GRANT with ack=0 and cnt == TIMEOUT-1 at an edge, the block SHALL at that edge do all of the following:
- Y <= 0
- valid <= 0
- timeout <= 1
- ptr <= index of current grant
- state <= IDLE
REQ-017: In GRANT with ack=0 and cnt < TIMEOUT-1, the block SHALL increment cnt and hold all outputs. A grant is therefore visible for at most TIMEOUT cycles.
REQ-018: If ack=1 coincides with cnt == TIMEOUT-1, ack SHALL win: normal release with timeout=0.
REQ-019: timeout SHALL return to 0 on the edge after it is asserted; it is never high for more than one cycle.
REQ-020: After any release (ack or timeout), Y SHALL be 0 for at least one full cycle before the next grant, so the encoder sees a gap.
REQ-021: ack while in IDLE SHALL be ignored, with no change to state or outputs.
REQ-022: Only bit index values SHALL be stored in ptr; ptr SHALL wrap modulo 4. cnt SHALL never exceed TIMEOUT-1.
REQ-023: With TIMEOUT=1 and no ack, each grant SHALL last exactly one cycle and be followed by a timeout pulse.

Reset
REQ-024: While rst=1, the block SHALL hold, immediately and independent of clk:
- state=IDLE
- Y=4'b0000
- valid=0
- timeout=0
- cnt=0
- ptr=3, so req[0] has top priority after reset
REQ-025: rst asserted mid-grant SHALL drop Y to 0 without a timeout pulse and without updating ptr beyond its reset value.
REQ-026: On the first edge after rst deasserts, the block SHALL evaluate req per REQ-012.

Verification
REQ-027: Reset, then req=4'b1111 with ack pulsed 1 cycle after each grant -> Y sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-028: req=4'b0100 held, ack=0, TIMEOUT=8 -> Y=0100 for exactly 8 cycles, then Y=0000 with timeout=1 for one cycle, then Y=0100 again.
REQ-029: Grant on bit 2, req dropped to 0 the next cycle -> Y stays 0100 until ack; no early release.
REQ-030: ack=1 on the same edge where cnt=TIMEOUT-1 -> release with timeout=0 and ptr updated to the granted index.
REQ-031: rst pulsed while Y=1000 -> Y=0000 and valid=0 asynchronously; after release with req=4'b1001 -> next Y=0001.
REQ-032: Every cycle, the bench SHALL check:
- Y is zero or one-hot
- valid equals (Y != 0)
- timeout is never high for 2 consecutive cycles
